r2_twiddle_stage: RTL



---
 rtl/fft_pkg.sv | 38 +++
 rtl/r2_twiddle_rom.sv | 47 ++++
 rtl/r2_twiddle_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Fixed-point widths, saturation bounds and the complex sample type shared by the radix-2 FFT datapath.
// Also provides the round-half-up / saturate helper used to bring Q2.16 products back to 18 bits.
package fft_pkg;

    localparam int DATA_W  = 18;
    localparam int TW_W    = 18;
    localparam int TW_FRAC = 16;
    localparam int PROD_W  = DATA_W + TW_W;
    localparam int SUM_W   = PROD_W + 1;
    localparam int SHR_W   = SUM_W - TW_FRAC;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0]  RND_HALF =
        {{(SUM_W-TW_FRAC){1'b0}}, 1'b1, {(TW_FRAC-1){1'b0}}};

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    // Keeping the top SHR_W bits of the biased sum is the arithmetic shift; it fits
    // the output only when all bits above the 18-bit sign agree with the sign.
    function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [SUM_W-1:0] x);
        logic signed [SUM_W-1:0] r;
        logic [SHR_W-1:0]        q;
        r = x + RND_HALF;
        q = r[SUM_W-1:TW_FRAC];
        if (!q[SHR_W-1] && (|q[SHR_W-2:DATA_W-1])) begin
            round_sat = SAT_MAX;
        end else if (q[SHR_W-1] && !(&q[SHR_W-2:DATA_W-1])) begin
            round_sat = SAT_MIN;
        end else begin
            round_sat = q[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/r2_twiddle_rom.sv
// N/2-entry twiddle ROM {re, im} in signed Q2.16, cos / -sin of 2*pi*k/N; one-cycle registered read.
// No backpressure: a new address is accepted every cycle.
module r2_twiddle_rom
    import fft_pkg::*;
#(
    parameter int    LOG2N      = 10,
    parameter string TW_RE_FILE = "tw_re.hex",
    parameter string TW_IM_FILE = "tw_im.hex"
) (
    input  logic                   clk,
    input  logic [LOG2N-2:0]       addr,
    output logic [2*TW_W-1:0]      rd_dat
);

    localparam int DEPTH = 1 << (LOG2N - 1);

    // Contents are generated at elaboration so the image always matches LOG2N.
    function automatic logic [2*TW_W-1:0] tw_entry(input int k);
        real ang;
        int  c;
        int  s;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(2 * DEPTH);
        c   = $rtoi($floor(real'(1 << TW_FRAC) * $cos(ang) + 0.5));
        s   = $rtoi($floor(-real'(1 << TW_FRAC) * $sin(ang) + 0.5));
        return {c[TW_W-1:0], s[TW_W-1:0]};
    endfunction

    logic [2*TW_W-1:0] rom_w [DEPTH];
    logic [2*TW_W-1:0] rd_dat_d;
    logic [2*TW_W-1:0] rd_dat_q;

    for (genvar gk = 0; gk < DEPTH; gk++) begin : g_rom
        localparam logic [2*TW_W-1:0] ENTRY = tw_entry(gk);
        assign rom_w[gk] = ENTRY;
    end

    always_comb begin
        rd_dat_d = rom_w[addr];
    end

    always_ff @(posedge clk) begin
        rd_dat_q <= rd_dat_d;
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/r2_twiddle_stage.sv
// Radix-2 DIF twiddle stage: s1 delayed, s2 * W_N^k rounded and saturated to 18 bits.
// Fixed 4-cycle latency, one butterfly per cycle; no backpressure, input gaps pass through unchanged.
module r2_twiddle_stage
    import fft_pkg::*;
#(
    parameter int    LOG2N      = 10,
    parameter int    STAGE      = 0,
    parameter string TW_RE_FILE = "tw_re.hex",
    parameter string TW_IM_FILE = "tw_im.hex"
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_first,
    input  logic signed [DATA_W-1:0] s1r,
    input  logic signed [DATA_W-1:0] s1i,
    input  logic signed [DATA_W-1:0] s2r,
    input  logic signed [DATA_W-1:0] s2i,
    output logic                     out_valid,
    output logic                     out_last,
    output logic signed [DATA_W-1:0] y1r,
    output logic signed [DATA_W-1:0] y1i,
    output logic signed [DATA_W-1:0] y2r,
    output logic signed [DATA_W-1:0] y2i
);

    localparam int             CW       = LOG2N - 1;
    localparam logic [CW-1:0]  LAST_IDX = '1;
    localparam logic [CW-1:0]  K_MASK   = CW'((1 << (CW - STAGE)) - 1);

    logic [CW-1:0] cnt_d, cnt_q;
    logic [CW-1:0] idx, k;

    logic          c0_vld_d, c0_vld_q, c0_last_d, c0_last_q;
    logic [CW-1:0] c0_k_d, c0_k_q;
    cplx_t         c0_s1_d, c0_s1_q, c0_s2_d, c0_s2_q;

    logic          c1_vld_d, c1_vld_q, c1_last_d, c1_last_q;
    cplx_t         c1_s1_d, c1_s1_q, c1_s2_d, c1_s2_q;
    logic [2*TW_W-1:0]       tw_dat;
    logic signed [TW_W-1:0]  tw_re, tw_im;

    logic          c2_vld_d, c2_vld_q, c2_last_d, c2_last_q;
    cplx_t         c2_s1_d, c2_s1_q;
    logic signed [PROD_W-1:0] c2_prr_d, c2_prr_q, c2_pii_d, c2_pii_q;
    logic signed [PROD_W-1:0] c2_pri_d, c2_pri_q, c2_pir_d, c2_pir_q;

    logic signed [SUM_W-1:0] sum_re, sum_im;
    logic          out_vld_d, out_vld_q, out_last_d, out_last_q;
    cplx_t         y1_d, y1_q, y2_d, y2_q;

    r2_twiddle_rom #(
        .LOG2N      (LOG2N),
        .TW_RE_FILE (TW_RE_FILE),
        .TW_IM_FILE (TW_IM_FILE)
    ) u_rom (
        .clk    (clk),
        .addr   (c0_k_q),
        .rd_dat (tw_dat)
    );

    always_comb begin
        // in_first forces index 0, which also covers a first that lands on a wrap.
        idx   = in_first ? '0 : cnt_q;
        cnt_d = cnt_q;
        if (in_valid) begin
            cnt_d = idx + 1'b1;
        end
        k = (idx & K_MASK) << STAGE;

        c0_vld_d  = in_valid;
        c0_last_d = in_valid && (idx == LAST_IDX);
        c0_k_d    = k;
        c0_s1_d   = '{re: s1r, im: s1i};
        c0_s2_d   = '{re: s2r, im: s2i};

        c1_vld_d  = c0_vld_q;
        c1_last_d = c0_last_q;
        c1_s1_d   = c0_s1_q;
        c1_s2_d   = c0_s2_q;

        tw_re     = tw_dat[2*TW_W-1:TW_W];
        tw_im     = tw_dat[TW_W-1:0];
        c2_vld_d  = c1_vld_q;
        c2_last_d = c1_last_q;
        c2_s1_d   = c1_s1_q;
        c2_prr_d  = PROD_W'(c1_s2_q.re) * PROD_W'(tw_re);
        c2_pii_d  = PROD_W'(c1_s2_q.im) * PROD_W'(tw_im);
        c2_pri_d  = PROD_W'(c1_s2_q.re) * PROD_W'(tw_im);
        c2_pir_d  = PROD_W'(c1_s2_q.im) * PROD_W'(tw_re);

        sum_re     = SUM_W'(c2_prr_q) - SUM_W'(c2_pii_q);
        sum_im     = SUM_W'(c2_pri_q) + SUM_W'(c2_pir_q);
        out_vld_d  = c2_vld_q;
        out_last_d = c2_vld_q && c2_last_q;
        y1_d       = y1_q;
        y2_d       = y2_q;
        if (c2_vld_q) begin
            y1_d = c2_s1_q;
            y2_d = '{re: round_sat(sum_re), im: round_sat(sum_im)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            c0_vld_q   <= 1'b0;
            c0_last_q  <= 1'b0;
            c0_k_q     <= '0;
            c0_s1_q    <= '0;
            c0_s2_q    <= '0;
            c1_vld_q   <= 1'b0;
            c1_last_q  <= 1'b0;
            c1_s1_q    <= '0;
            c1_s2_q    <= '0;
            c2_vld_q   <= 1'b0;
            c2_last_q  <= 1'b0;
            c2_s1_q    <= '0;
            c2_prr_q   <= '0;
            c2_pii_q   <= '0;
            c2_pri_q   <= '0;
            c2_pir_q   <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            y1_q       <= '0;
            y2_q       <= '0;
        end else begin
            cnt_q      <= cnt_d;
            c0_vld_q   <= c0_vld_d;
            c0_last_q  <= c0_last_d;
            c0_k_q     <= c0_k_d;
            c0_s1_q    <= c0_s1_d;
            c0_s2_q    <= c0_s2_d;
            c1_vld_q   <= c1_vld_d;
            c1_last_q  <= c1_last_d;
            c1_s1_q    <= c1_s1_d;
            c1_s2_q    <= c1_s2_d;
            c2_vld_q   <= c2_vld_d;
            c2_last_q  <= c2_last_d;
            c2_s1_q    <= c2_s1_d;
            c2_prr_q   <= c2_prr_d;
            c2_pii_q   <= c2_pii_d;
            c2_pri_q   <= c2_pri_d;
            c2_pir_q   <= c2_pir_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            y1_q       <= y1_d;
            y2_q       <= y2_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_last  = out_last_q;
    assign y1r       = y1_q.re;
    assign y1i       = y1_q.im;
    assign y2r       = y2_q.re;
    assign y2i       = y2_q.im;

endmodule
